button_debouncer: RTL and testbench

- Parametrised successor to the plain button-bus splitter.
- Takes a bus of NUM_BUTTONS raw, asynchronous push-button pins and, per channel:
  - synchronises it to `clk`;
  - normalises its polarity;
  - debounces it with a stable-time counter;
  - produces registered level, press-pulse and release-pulse outputs.
- Sits between the board button pins and the PL logic or PS GPIO/interrupt fabric that consumes button events.
- Optionally latches presses into sticky flags that drive one interrupt line.

---
 rtl/button_debouncer.sv | 103 ++++++++++
 tb/tb_button_debouncer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Per-channel synchroniser, polarity fix and stable-time debouncer with registered level and edge pulses.
// Define BTN_IRQ_EN to add sticky press flags and a combined interrupt line.
module button_debouncer #(
  parameter int NUM_BUTTONS     = 8,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_BUTTONS-1:0] buttons_db,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  input  logic [NUM_BUTTONS-1:0] irq_clear,
  output logic [NUM_BUTTONS-1:0] press_latched,
  output logic                   irq
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [0:0]      ST_STABLE   = 1'b0;
  localparam logic [0:0]      ST_COUNTING = 1'b1;

  logic [NUM_BUTTONS-1:0] norm;
  logic [NUM_BUTTONS-1:0] s1_q, s1_d;
  logic [NUM_BUTTONS-1:0] s2_q, s2_d;
  logic [NUM_BUTTONS-1:0] db_q, db_d;
  logic [NUM_BUTTONS-1:0] press_q, press_d;
  logic [NUM_BUTTONS-1:0] rel_q, rel_d;
  logic [CW-1:0]          cnt_q [NUM_BUTTONS];
  logic [CW-1:0]          cnt_d [NUM_BUTTONS];
  // Per-channel FSM state, derived from the counter: STABLE when it is zero.
  logic [NUM_BUTTONS-1:0] state;

  assign norm = (ACTIVE_LOW != 0) ? ~buttons : buttons;

  always_comb begin
    s1_d    = norm;
    s2_d    = s1_q;
    db_d    = db_q;
    press_d = '0;
    rel_d   = '0;
    state   = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = cnt_q[i];
      state[i] = (cnt_q[i] != '0) ? ST_COUNTING : ST_STABLE;
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        // Covers both a long count and DEBOUNCE_CYCLES=1, where STABLE accepts directly.
        db_d[i]    = s2_q[i];
        cnt_d[i]   = '0;
        press_d[i] = s2_q[i];
        rel_d[i]   = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q    <= '0;
      s2_q    <= '0;
      db_q    <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      db_q    <= db_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign buttons_db    = db_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

`ifdef BTN_IRQ_EN
  logic [NUM_BUTTONS-1:0] latched_q, latched_d;

  // A new press on the same edge as a clear keeps the flag set.
  always_comb latched_d = (latched_q & ~irq_clear) | press_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) latched_q <= '0;
    else         latched_q <= latched_d;
  end

  assign press_latched = latched_q;
  assign irq           = |latched_q;
`else
  logic unused_irq_clear;
  assign unused_irq_clear = ^irq_clear;
  assign press_latched    = '0;
  assign irq              = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: an active-high and an active-low instance, pulses checked by a scoreboard.
module tb_button_debouncer;

  localparam int N   = 4;
  localparam int D   = 4;
  localparam int LAT = D + 2;
  localparam int EW  = 2 * N + 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [N-1:0] buttons = '0;
  logic [N-1:0] buttons_al = '1;
  logic [N-1:0] irq_clear = '0;

  logic [N-1:0] db, pp, rp, latched;
  logic         irq;
  logic [N-1:0] db_al, pp_al, rp_al, latched_al;
  logic         irq_al;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_al_q[$];
  logic [EW-1:0] e_main, e_al;

  button_debouncer #(.NUM_BUTTONS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0)) dut (
    .clk(clk), .resetn(resetn), .buttons(buttons), .buttons_db(db),
    .press_pulse(pp), .release_pulse(rp), .irq_clear(irq_clear),
    .press_latched(latched), .irq(irq)
  );

  button_debouncer #(.NUM_BUTTONS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .resetn(resetn), .buttons(buttons_al), .buttons_db(db_al),
    .press_pulse(pp_al), .release_pulse(rp_al), .irq_clear(irq_clear),
    .press_latched(latched_al), .irq(irq_al)
  );

  // Clock, free-running edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input logic [N-1:0] p, input logic [N-1:0] r, input int at);
    exp_q.push_back({p, r, 32'(at)});
  endtask

  task automatic expect_pulse_al(input logic [N-1:0] p, input logic [N-1:0] r, input int at);
    exp_al_q.push_back({p, r, 32'(at)});
  endtask

  // Scoreboard monitors: any pulse must match the oldest expected {press, release, cycle}
  always @(negedge clk) begin
    if (resetn && ((pp | rp) != '0)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pulse_unexpected actual=%b/%b at %0d required=none", pp, rp, cyc);
      end else begin
        e_main = exp_q.pop_front();
        if ({pp, rp, 32'(cyc)} !== e_main) begin
          bad++;
          $display("FAIL pulse actual=%b/%b@%0d required=%b/%b@%0d", pp, rp, cyc,
                   e_main[EW-1 -: N], e_main[N+31 -: N], e_main[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && ((pp_al | rp_al) != '0)) begin
      total++;
      if (exp_al_q.size() == 0) begin
        bad++;
        $display("FAIL pulse_al_unexpected actual=%b/%b at %0d required=none", pp_al, rp_al, cyc);
      end else begin
        e_al = exp_al_q.pop_front();
        if ({pp_al, rp_al, 32'(cyc)} !== e_al) begin
          bad++;
          $display("FAIL pulse_al actual=%b/%b@%0d required=%b/%b@%0d", pp_al, rp_al, cyc,
                   e_al[EW-1 -: N], e_al[N+31 -: N], e_al[31:0]);
        end
      end
    end
  end

  initial begin
    // Reset state
    step(3);
    check("rst_db", db, 0);
    check("rst_pulses", {pp, rp}, 0);
    check("rst_latched_irq", {latched, irq}, 0);
    check("rst_al_all", {db_al, pp_al, rp_al, latched_al, irq_al}, 0);
    resetn = 1'b1;
    step(2);

    // Clean press and release on ch0
    buttons = 4'b0001;
    expect_pulse(4'b0001, 4'b0000, cyc + LAT);
    step(LAT);
    check("clean_press_db", db, 4'b0001);
    step(2);
    buttons = 4'b0000;
    expect_pulse(4'b0000, 4'b0001, cyc + LAT);
    step(LAT + 2);
    check("clean_release_db", db, 4'b0000);

    // Bounce rejection on ch1, then a genuine hold
    buttons[1] = 1'b1; step(3);
    buttons[1] = 1'b0; step(1);
    buttons[1] = 1'b1; step(3);
    buttons[1] = 1'b0; step(2);
    check("bounce_db", db, 4'b0000);
    buttons[1] = 1'b1;
    expect_pulse(4'b0010, 4'b0000, cyc + LAT);
    step(LAT + 2);
    check("bounce_hold_db", db, 4'b0010);
    buttons[1] = 1'b0;
    expect_pulse(4'b0000, 4'b0010, cyc + LAT);
    step(LAT + 2);

    // Active-low instance, ch2
    buttons_al[2] = 1'b0;
    expect_pulse_al(4'b0100, 4'b0000, cyc + LAT);
    step(LAT);
    check("al_press_db", db_al, 4'b0100);
    step(2);
    buttons_al = '1;
    expect_pulse_al(4'b0000, 4'b0100, cyc + LAT);
    step(LAT + 2);
    check("al_release_db", db_al, 4'b0000);

    // Simultaneous ch0+ch3 press, staggered releases
    buttons = 4'b1001;
    expect_pulse(4'b1001, 4'b0000, cyc + LAT);
    step(LAT + 2);
    check("multi_press_db", db, 4'b1001);
    buttons[3] = 1'b0;
    expect_pulse(4'b0000, 4'b1000, cyc + LAT);
    step(2);
    buttons[0] = 1'b0;
    expect_pulse(4'b0000, 4'b0001, cyc + LAT);
    step(LAT + 2);
    check("multi_release_db", db, 4'b0000);

`ifdef BTN_IRQ_EN
    check("sticky_accum", {latched, irq}, {4'b1011, 1'b1});
`else
    check("no_irq_accum", {latched, irq}, 0);
`endif

    // Reset in the middle of a count
    buttons = 4'b0100;
    expect_pulse(4'b0100, 4'b0000, cyc + LAT);
    step(LAT + 2);
    buttons = 4'b0101;
    step(4);
    resetn = 1'b0;
    #1;
    check("midrst_db", db, 4'b0000);
    check("midrst_other", {pp, rp, latched, irq}, 0);
    step(2);
    resetn = 1'b1;
    expect_pulse(4'b0101, 4'b0000, cyc + LAT);
    step(LAT + 2);
    check("post_rst_db", db, 4'b0101);
    buttons = 4'b0000;
    expect_pulse(4'b0000, 4'b0101, cyc + LAT);
    step(LAT + 2);

    // Sticky flags and interrupt
    irq_clear = '1; step(1); irq_clear = '0;
    check("irq_clear_all", {latched, irq}, 0);
    buttons = 4'b0100;
    expect_pulse(4'b0100, 4'b0000, cyc + LAT);
    step(LAT);
    check("irq_not_yet", {latched, irq}, 0);
    step(1);
`ifdef BTN_IRQ_EN
    check("irq_set", {latched, irq}, {4'b0100, 1'b1});
`else
    check("irq_off_set", {latched, irq}, 0);
`endif
    buttons = 4'b0000;
    expect_pulse(4'b0000, 4'b0100, cyc + LAT);
    step(LAT + 2);
    irq_clear = 4'b0100; step(1); irq_clear = '0;
    check("irq_clear_alone", {latched, irq}, 0);
    buttons = 4'b0100;
    expect_pulse(4'b0100, 4'b0000, cyc + LAT);
    step(LAT);
    irq_clear = 4'b0100; step(1); irq_clear = '0;
`ifdef BTN_IRQ_EN
    check("irq_set_wins", {latched, irq}, {4'b0100, 1'b1});
`else
    check("irq_off_set_wins", {latched, irq}, 0);
`endif
    buttons = 4'b0000;
    expect_pulse(4'b0000, 4'b0100, cyc + LAT);
    step(LAT + 2);
    irq_clear = 4'b0100; step(1); irq_clear = '0;
    check("irq_final_clear", {latched, irq}, 0);

    // Final report
    step(2);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_al_q_drained", exp_al_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
